// File: rtl/layer_bridge.sv
// Collects one layer's parallel neuron outputs, double-buffers the vector,
// streams it over valid/ready and optionally reports a signed argmax.
module layer_bridge #(
    parameter int NN         = 10,
    parameter int DATA_WIDTH = 16,
    parameter int IDX_WIDTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NN-1:0]            x_valid,
    input  logic [NN*DATA_WIDTH-1:0] x_in,
    output logic                     in_ready,
    input  logic                     argmax_en,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last,
    output logic [IDX_WIDTH-1:0]     max_idx,
    output logic [DATA_WIDTH-1:0]    max_val,
    output logic                     max_valid,
    output logic                     overflow,
    input  logic                     clr_overflow
);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        REPORT
    } state_t;

    state_t state, state_nxt;

    logic [DATA_WIDTH-1:0] coll  [NN];
    logic [DATA_WIDTH-1:0] drain [NN];
    logic [NN-1:0]         flags;
    logic [IDX_WIDTH-1:0]  idx;
    logic                  mode;
    logic [DATA_WIDTH-1:0] run_val;
    logic [IDX_WIDTH-1:0]  run_idx;

    logic                  full;
    logic                  xfer;
    logic                  accept;
    logic                  last_beat;
    logic                  better;
    logic                  ovf_set;
    logic [DATA_WIDTH-1:0] cur;
    logic [DATA_WIDTH-1:0] nxt_val;
    logic [IDX_WIDTH-1:0]  nxt_idx;

    assign full      = &flags;
    assign in_ready  = !full;
    assign xfer      = full && (state == IDLE);
    assign accept    = out_valid && out_ready;
    assign last_beat = (idx == IDX_WIDTH'(NN - 1));
    // Refills racing a transfer belong to the next vector, not an overflow.
    assign ovf_set   = |(x_valid & flags & ~{NN{xfer}});

    always_comb begin
        cur = '0;
        for (int i = 0; i < NN; i++) begin
            if (idx == IDX_WIDTH'(i)) cur = drain[i];
        end
    end

    // Strict compare keeps the lower index on ties.
    assign better  = (idx == '0) || ($signed(cur) > $signed(run_val));
    assign nxt_val = better ? cur : run_val;
    assign nxt_idx = better ? idx : run_idx;

    always_comb begin
        state_nxt = state;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = '0;
        max_valid = 1'b0;
        unique case (state)
            IDLE: begin
                if (xfer) state_nxt = STREAM;
            end
            STREAM: begin
                out_valid = 1'b1;
                out_data  = cur;
                out_last  = last_beat;
                if (out_ready && last_beat) begin
                    state_nxt = mode ? REPORT : IDLE;
                end
            end
            REPORT: begin
                max_valid = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags <= '0;
            for (int i = 0; i < NN; i++) coll[i] <= '0;
        end else begin
            for (int i = 0; i < NN; i++) begin
                if (x_valid[i] && (!flags[i] || xfer)) begin
                    coll[i] <= x_in[i*DATA_WIDTH +: DATA_WIDTH];
                end
                flags[i] <= x_valid[i] || (flags[i] && !xfer);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            mode    <= 1'b0;
            run_val <= '0;
            run_idx <= '0;
            max_val <= '0;
            max_idx <= '0;
            for (int i = 0; i < NN; i++) drain[i] <= '0;
        end else begin
            state <= state_nxt;
            if (xfer) begin
                for (int i = 0; i < NN; i++) drain[i] <= coll[i];
                mode <= argmax_en;
                idx  <= '0;
            end
            if (accept) begin
                idx     <= last_beat ? '0 : idx + 1'b1;
                run_val <= nxt_val;
                run_idx <= nxt_idx;
                if (last_beat && mode) begin
                    max_val <= nxt_val;
                    max_idx <= nxt_idx;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (ovf_set) begin
            overflow <= 1'b1;
        end else if (clr_overflow) begin
            overflow <= 1'b0;
        end
    end

endmodule
